decode_buf: RTL and testbench

DECODE_BUF -- requirements
Module: decode_buf

---
 rtl/decode_buf_pkg.sv | 57 +++++
 rtl/decode_buf_decoder.sv | 81 ++++++++
 rtl/decode_buf_imm_gen.sv | 36 +++
 rtl/decode_buf.sv | 130 +++++++++++++
 tb/tb_decode_buf.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/decode_buf_pkg.sv
// Shared pipeline definitions for the decode buffer: RV64I opcodes, the
// immediate-format enum, the decoded control bundle and a format lookup.
package decode_buf_pkg;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_fmt_e;

    typedef struct packed {
        logic     valid;
        logic     uses_rs1;
        logic     uses_rs2;
        logic     writes_rd;
        logic     is_load;
        logic     is_store;
        logic     is_branch;
        logic     is_jal;
        logic     is_jalr;
        logic     is_lui;
        logic     is_auipc;
        logic     is_word;
        imm_fmt_e imm_fmt;
    } control_t;

    function automatic imm_fmt_e imm_fmt_of(input logic [6:0] opcode);
        imm_fmt_e fmt;
        case (opcode)
            OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM32, OPC_JALR: fmt = IMM_I;
            OPC_STORE:                                    fmt = IMM_S;
            OPC_BRANCH:                                   fmt = IMM_B;
            OPC_LUI, OPC_AUIPC:                           fmt = IMM_U;
            OPC_JAL:                                      fmt = IMM_J;
            default:                                      fmt = IMM_NONE;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/decode_buf_decoder.sv
// Opcode-level control decoder: which register ports an instruction reads,
// whether it writes rd, its class and its immediate format.
module decoder
    import decode_buf_pkg::*;
(
    input  logic [6:0] opcode,
    output control_t   ctl
);

    control_t ctl_s;

    // Classify the opcode into the control bundle.
    always_comb begin
        ctl_s         = '{default: 1'b0, imm_fmt: IMM_NONE};
        ctl_s.imm_fmt = imm_fmt_of(opcode);
        ctl_s.valid   = 1'b1;
        case (opcode)
            OPC_LOAD: begin
                ctl_s.uses_rs1  = 1'b1;
                ctl_s.writes_rd = 1'b1;
                ctl_s.is_load   = 1'b1;
            end
            OPC_OP_IMM: begin
                ctl_s.uses_rs1  = 1'b1;
                ctl_s.writes_rd = 1'b1;
            end
            OPC_OP_IMM32: begin
                ctl_s.uses_rs1  = 1'b1;
                ctl_s.writes_rd = 1'b1;
                ctl_s.is_word   = 1'b1;
            end
            OPC_STORE: begin
                ctl_s.uses_rs1 = 1'b1;
                ctl_s.uses_rs2 = 1'b1;
                ctl_s.is_store = 1'b1;
            end
            OPC_BRANCH: begin
                ctl_s.uses_rs1  = 1'b1;
                ctl_s.uses_rs2  = 1'b1;
                ctl_s.is_branch = 1'b1;
            end
            OPC_JALR: begin
                ctl_s.uses_rs1  = 1'b1;
                ctl_s.writes_rd = 1'b1;
                ctl_s.is_jalr   = 1'b1;
            end
            OPC_JAL: begin
                ctl_s.writes_rd = 1'b1;
                ctl_s.is_jal    = 1'b1;
            end
            OPC_LUI: begin
                ctl_s.writes_rd = 1'b1;
                ctl_s.is_lui    = 1'b1;
            end
            OPC_AUIPC: begin
                ctl_s.writes_rd = 1'b1;
                ctl_s.is_auipc  = 1'b1;
            end
            OPC_OP: begin
                ctl_s.uses_rs1  = 1'b1;
                ctl_s.uses_rs2  = 1'b1;
                ctl_s.writes_rd = 1'b1;
            end
            OPC_OP32: begin
                ctl_s.uses_rs1  = 1'b1;
                ctl_s.uses_rs2  = 1'b1;
                ctl_s.writes_rd = 1'b1;
                ctl_s.is_word   = 1'b1;
            end
            OPC_MISC_MEM, OPC_SYSTEM: begin
                ctl_s.valid = 1'b1;
            end
            default: begin
                ctl_s.valid = 1'b0;
            end
        endcase
    end

    assign ctl = ctl_s;

endmodule

// File: rtl/decode_buf_imm_gen.sv
// Immediate generator: extracts the I/S/B/U/J immediate selected by the
// opcode and sign-extends it from instr[31] to XLEN.
module imm_gen
    import decode_buf_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm
);

    imm_fmt_e        fmt_s;
    logic            sign_s;
    logic [XLEN-1:0] imm_s;

    assign fmt_s  = imm_fmt_of(instr[6:0]);
    assign sign_s = instr[31];

    // Reassemble the scattered immediate fields for each format.
    always_comb begin
        imm_s = {XLEN{1'b0}};
        case (fmt_s)
            IMM_I: imm_s = {{(XLEN-12){sign_s}}, instr[31:20]};
            IMM_S: imm_s = {{(XLEN-12){sign_s}}, instr[31:25], instr[11:7]};
            IMM_B: imm_s = {{(XLEN-13){sign_s}}, sign_s, instr[7], instr[30:25],
                            instr[11:8], 1'b0};
            IMM_U: imm_s = {{(XLEN-32){sign_s}}, instr[31:12], 12'h000};
            IMM_J: imm_s = {{(XLEN-21){sign_s}}, sign_s, instr[19:12], instr[20],
                            instr[30:21], 1'b0};
            default: imm_s = {XLEN{1'b0}};
        endcase
    end

    assign imm = imm_s;

endmodule

// File: rtl/decode_buf.sv
// Decode buffer: circular FIFO of fetched {pc, instr} with zero-latency decode
// of the head entry and a load-use hazard stall against the execute stage.
module decode_buf
    import decode_buf_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [XLEN-1:0]          in_pc,
    input  logic [31:0]              in_instr,
    input  logic                     flush,
    input  logic                     ex_is_load,
    input  logic [4:0]               ex_rd,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_pc,
    output control_t                 out_ctl,
    output logic [XLEN-1:0]          out_imm,
    output logic [4:0]               out_ra1,
    output logic [4:0]               out_ra2,
    output logic [4:0]               out_rd,
    output logic                     stall,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [XLEN-1:0]  pc_mem_q    [DEPTH];
    logic [31:0]      instr_mem_q [DEPTH];

    logic [PTR_W-1:0] head_q,  head_d;
    logic [PTR_W-1:0] tail_q,  tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             empty_s;
    logic             full_s;
    logic             push_s;
    logic             pop_s;
    logic             hazard_s;
    logic [31:0]      head_instr_s;

    assign empty_s      = (count_q == CNT_W'(0));
    assign full_s       = (count_q == CNT_W'(DEPTH));
    assign head_instr_s = instr_mem_q[head_q];

    decoder u_decoder (
        .opcode (head_instr_s[6:0]),
        .ctl    (out_ctl)
    );

    imm_gen #(
        .XLEN (XLEN)
    ) u_imm_gen (
        .instr (head_instr_s),
        .imm   (out_imm)
    );

    assign out_pc  = pc_mem_q[head_q];
    assign out_ra1 = head_instr_s[19:15];
    assign out_ra2 = head_instr_s[24:20];
    assign out_rd  = head_instr_s[11:7];

    // A load writing x0 never produces a value anyone waits for.
    assign hazard_s = !empty_s && ex_is_load && (ex_rd != 5'd0) &&
                      ((out_ctl.uses_rs1 && (ex_rd == out_ra1)) ||
                       (out_ctl.uses_rs2 && (ex_rd == out_ra2)));

    assign stall     = hazard_s;
    assign out_valid = !empty_s && !hazard_s;
    assign in_ready  = !full_s;
    assign count     = count_q;

    assign push_s = in_valid && !full_s && !flush;
    assign pop_s  = out_valid && out_ready && !flush;

    // Next pointer/occupancy state; flush discards everything in flight.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = {PTR_W{1'b0}};
            tail_d  = {PTR_W{1'b0}};
            count_d = {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                tail_d = tail_q + PTR_W'(1);
            end else begin
                tail_d = tail_q;
            end
            if (pop_s) begin
                head_d = head_q + PTR_W'(1);
            end else begin
                head_d = head_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= {PTR_W{1'b0}};
            tail_q  <= {PTR_W{1'b0}};
            count_q <= {CNT_W{1'b0}};
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are qualified by count so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            pc_mem_q[tail_q]    <= in_pc;
            instr_mem_q[tail_q] <= in_instr;
        end
    end

endmodule

// File: tb/tb_decode_buf.sv
// Directed bench for decode_buf (XLEN=64, DEPTH=4) with hand-computed
// expectations and a small queue model for the full-throughput phase.
module tb_decode_buf;
    import decode_buf_pkg::*;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_pc;
    logic [31:0] in_instr;
    logic        flush;
    logic        ex_is_load;
    logic [4:0]  ex_rd;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    control_t    out_ctl;
    logic [63:0] out_imm;
    logic [4:0]  out_ra1;
    logic [4:0]  out_ra2;
    logic [4:0]  out_rd;
    logic        stall;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    decode_buf #(.XLEN(64), .DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pc      (in_pc),
        .in_instr   (in_instr),
        .flush      (flush),
        .ex_is_load (ex_is_load),
        .ex_rd      (ex_rd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pc     (out_pc),
        .out_ctl    (out_ctl),
        .out_imm    (out_imm),
        .out_ra1    (out_ra1),
        .out_ra2    (out_ra2),
        .out_rd     (out_rd),
        .stall      (stall),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] addi(input int rd, input int imm);
        logic [11:0] i12;
        logic [4:0]  r5;
        i12 = imm[11:0];
        r5  = rd[4:0];
        return {i12, 5'd0, 3'b000, r5, 7'h13};
    endfunction

    task automatic push_one(input logic [63:0] pc, input logic [31:0] instr);
        in_valid = 1'b1;
        in_pc    = pc;
        in_instr = instr;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    logic [63:0] exp_q[$];
    int          next_idx;
    logic        push_m;
    logic        pop_m;
    int          head_idx;

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_pc      = 64'h0;
        in_instr   = 32'h0;
        flush      = 1'b0;
        ex_is_load = 1'b0;
        ex_rd      = 5'd0;
        out_ready  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("reset_count",     {61'd0, count}, 64'd0);
        check("reset_in_ready",  {63'd0, in_ready}, 64'd1);
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_stall",     {63'd0, stall}, 64'd0);

        // First push: ADDI x1,x0,-1 is visible the cycle after acceptance.
        push_one(64'h0000_0000_8000_0000, 32'hFFF0_0093);
        check("addi_count",     {61'd0, count}, 64'd1);
        check("addi_out_valid", {63'd0, out_valid}, 64'd1);
        check("addi_imm",       out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        check("addi_rd",        {59'd0, out_rd}, 64'd1);
        check("addi_pc",        out_pc, 64'h0000_0000_8000_0000);
        check("addi_uses_rs2",  {63'd0, out_ctl.uses_rs2}, 64'd0);
        pop_one();
        check("pop_count",      {61'd0, count}, 64'd0);
        check("pop_out_valid",  {63'd0, out_valid}, 64'd0);

        // Fill with out_ready low; the fifth offer must be held back.
        for (int i = 0; i < 4; i++) begin
            push_one(64'h1000 + 64'(4 * i), addi(i + 1, i));
            exp_q.push_back(64'h1000 + 64'(4 * i));
        end
        check("full_count",    {61'd0, count}, 64'd4);
        check("full_in_ready", {63'd0, in_ready}, 64'd0);
        push_one(64'h1010, addi(5, 4));
        check("held_count",    {61'd0, count}, 64'd4);
        check("held_head_pc",  out_pc, 64'h1000);
        next_idx = 4;

        // Streaming from full across the pointer wrap, checked against a queue model.
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            in_valid = 1'b1;
            in_pc    = 64'h1000 + 64'(4 * next_idx);
            in_instr = addi(next_idx + 1, next_idx);
            #1;
            head_idx = int'((exp_q[0] - 64'h1000) >> 2);
            check("stream_pc",       out_pc, exp_q[0]);
            check("stream_rd",       {59'd0, out_rd}, 64'(head_idx + 1));
            check("stream_imm",      out_imm, 64'(head_idx));
            push_m = (exp_q.size() != 4);
            check("stream_in_ready", {63'd0, in_ready}, {63'd0, push_m});
            pop_m = (exp_q.size() != 0);
            tick();
            if (pop_m) void'(exp_q.pop_front());
            if (push_m) begin
                exp_q.push_back(64'h1000 + 64'(4 * next_idx));
                next_idx++;
            end
            check("stream_count", {61'd0, count}, 64'(exp_q.size()));
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("pre_flush_count", {61'd0, count}, 64'd3);

        // Flush with a push and pop offered in the same cycle.
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_pc     = 64'h3000;
        in_instr  = addi(7, 7);
        out_ready = 1'b1;
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        check("flush_count",     {61'd0, count}, 64'd0);
        check("flush_out_valid", {63'd0, out_valid}, 64'd0);
        check("flush_in_ready",  {63'd0, in_ready}, 64'd1);

        // Load-use hazard on ADD x3,x1,x2.
        push_one(64'h2000, 32'h0020_81B3);
        check("add_pc",       out_pc, 64'h2000);
        check("add_count",    {61'd0, count}, 64'd1);
        check("add_imm",      out_imm, 64'd0);
        check("add_ra1",      {59'd0, out_ra1}, 64'd1);
        check("add_ra2",      {59'd0, out_ra2}, 64'd2);
        check("add_rd",       {59'd0, out_rd}, 64'd3);
        check("add_uses_rs2", {63'd0, out_ctl.uses_rs2}, 64'd1);
        ex_is_load = 1'b1;
        ex_rd      = 5'd2;
        #1;
        check("haz_rs2_stall", {63'd0, stall}, 64'd1);
        check("haz_rs2_valid", {63'd0, out_valid}, 64'd0);
        ex_rd = 5'd1;
        #1;
        check("haz_rs1_stall", {63'd0, stall}, 64'd1);
        ex_rd = 5'd0;
        #1;
        check("haz_x0_stall", {63'd0, stall}, 64'd0);
        check("haz_x0_valid", {63'd0, out_valid}, 64'd1);
        ex_rd = 5'd3;
        #1;
        check("haz_rd_only_stall", {63'd0, stall}, 64'd0);
        ex_is_load = 1'b0;
        ex_rd      = 5'd2;
        #1;
        check("haz_noload_valid", {63'd0, out_valid}, 64'd1);
        ex_is_load = 1'b1;
        pop_one();
        check("haz_hold_count", {61'd0, count}, 64'd1);
        ex_is_load = 1'b0;
        ex_rd      = 5'd0;
        pop_one();
        check("haz_release_count", {61'd0, count}, 64'd0);

        // Immediate formats.
        push_one(64'h4000, 32'hFE20_AE23);
        check("imm_sw", out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
        pop_one();
        push_one(64'h4004, 32'hFE00_0CE3);
        check("imm_beq", out_imm, 64'hFFFF_FFFF_FFFF_FFF8);
        pop_one();
        push_one(64'h4008, 32'h8000_02B7);
        check("imm_lui", out_imm, 64'hFFFF_FFFF_8000_0000);
        pop_one();
        push_one(64'h400C, 32'h0010_00EF);
        check("imm_jal", out_imm, 64'h0000_0000_0000_0800);
        check("imm_jal_count", {61'd0, count}, 64'd1);

        // Reset wins over a simultaneous push.
        reset    = 1'b1;
        in_valid = 1'b1;
        in_pc    = 64'h5000;
        in_instr = addi(9, 9);
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst_prio_count",     {61'd0, count}, 64'd0);
        check("rst_prio_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_prio_in_ready",  {63'd0, in_ready}, 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
